mc_datapath_mul: RTL and testbench



---
 rtl/mc_datapath_mul.sv | 214 +++++++++++++++++++++
 tb/tb_mc_datapath_mul.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_mul.sv
`default_nettype none
// ============================================================================
// Module   : mc_datapath_mul
// Brief    : Multicycle ARM-subset datapath with a shift-add multiplier.
//            Define MC_DATAPATH_MLA_EN to seed the accumulator from ALUOut.
// Revision : 1.0
// ============================================================================
module mc_datapath_mul #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] Adr,
    output logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ReadData,
    output logic [31:0]     Instr,
    output logic [3:0]      ALUFlags,
    input  logic            PCWrite,
    input  logic            RegWrite,
    input  logic            IRWrite,
    input  logic            AdrSrc,
    input  logic [1:0]      RegSrc,
    input  logic            ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ImmSrc,
    input  logic [2:0]      ALUControl,
    input  logic            MulStart,
    output logic            MulBusy,
    output logic            MulDone
);

    localparam int        c_cw   = $clog2(XLEN);
    localparam [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [XLEN-1:0] r_pc, r_data, r_a, r_wd, r_aluout, r_mulout;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_rf [0:14];
    logic [1:0]      r_state, w_state_nxt;
    logic [XLEN-1:0] r_mcand, r_mplier, r_acc;
    logic [c_cw-1:0] r_cnt;

    logic [XLEN-1:0] w_result, w_rd1, w_rd2, w_srca, w_srcb, w_extimm, w_alu;
    logic [XLEN-1:0] w_b_eff, w_acc_nxt;
    logic [XLEN:0]   w_addsub;
    logic [31:0]     w_ext32, w_rd32;
    logic [3:0]      w_ra1, w_ra2, w_wa;
    logic            w_sub, w_c, w_v, w_busy, w_done;

    // ------------------------------------------------------------------
    // Width adaption between the 32-bit instruction world and XLEN
    // ------------------------------------------------------------------
    generate
        if (XLEN == 32) begin : g_w_eq
            assign w_extimm = w_ext32;
            assign w_rd32   = ReadData;
        end else if (XLEN > 32) begin : g_w_wide
            assign w_extimm = {{(XLEN-32){w_ext32[31]}}, w_ext32};
            assign w_rd32   = ReadData[31:0];
        end else begin : g_w_narrow
            assign w_extimm = w_ext32[XLEN-1:0];
            assign w_rd32   = {{(32-XLEN){1'b0}}, ReadData};
        end
    endgenerate

    // Bit 31 is the sign of every mode, so one sign-extension covers them all
    always_comb begin
        w_ext32 = 32'd0;
        case (ImmSrc)
            2'b00:   w_ext32 = {24'd0, r_instr[7:0]};
            2'b01:   w_ext32 = {20'd0, r_instr[11:0]};
            2'b10:   w_ext32 = {{6{r_instr[23]}}, r_instr[23:0], 2'b00};
            default: w_ext32 = 32'd0;
        endcase
    end

    always_comb begin
        w_result = r_aluout;
        case (ResultSrc)
            2'b00:   w_result = r_aluout;
            2'b01:   w_result = r_data;
            2'b10:   w_result = w_alu;
            default: w_result = r_mulout;
        endcase
    end

    assign w_ra1 = RegSrc[0] ? 4'd15 : r_instr[19:16];
    assign w_ra2 = RegSrc[1] ? r_instr[15:12] : r_instr[3:0];
    assign w_wa  = (r_instr[7:4] == 4'b1001) ? r_instr[19:16] : r_instr[15:12];
    assign w_rd1 = (w_ra1 == 4'd15) ? w_result : r_rf[w_ra1];
    assign w_rd2 = (w_ra2 == 4'd15) ? w_result : r_rf[w_ra2];

    assign w_srca = ALUSrcA ? r_pc : r_a;
    always_comb begin
        w_srcb = '0;
        case (ALUSrcB)
            2'b00:   w_srcb = r_wd;
            2'b01:   w_srcb = w_extimm;
            2'b10:   w_srcb = XLEN'(4);
            default: w_srcb = '0;
        endcase
    end

    // Subtract is a + ~b + 1, so carry-out doubles as no-borrow
    assign w_sub    = (ALUControl == 3'b001);
    assign w_b_eff  = w_sub ? ~w_srcb : w_srcb;
    assign w_addsub = {1'b0, w_srca} + {1'b0, w_b_eff} + {{XLEN{1'b0}}, w_sub};

    always_comb begin
        w_alu = w_srcb;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (ALUControl)
            3'b000, 3'b001: begin
                w_alu = w_addsub[XLEN-1:0];
                w_c   = w_addsub[XLEN];
                w_v   = (w_srca[XLEN-1] == w_b_eff[XLEN-1]) &&
                        (w_addsub[XLEN-1] != w_srca[XLEN-1]);
            end
            3'b010:  w_alu = w_srca & w_srcb;
            3'b011:  w_alu = w_srca | w_srcb;
            3'b100:  w_alu = w_srca ^ w_srcb;
            default: w_alu = w_srcb;
        endcase
    end

    assign ALUFlags  = {w_alu[XLEN-1], (w_alu == '0), w_c, w_v};
    assign Adr       = AdrSrc ? w_result : r_pc;
    assign WriteData = r_wd;
    assign Instr     = r_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= '0;
            r_instr  <= '0;
            r_data   <= '0;
            r_a      <= '0;
            r_wd     <= '0;
            r_aluout <= '0;
        end else begin
            if (PCWrite) r_pc    <= w_result;
            if (IRWrite) r_instr <= w_rd32;
            r_data   <= ReadData;
            r_a      <= w_rd1;
            r_wd     <= w_rd2;
            r_aluout <= w_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (RegWrite && (w_wa != 4'd15)) r_rf[w_wa] <= w_result;
    end

    // ------------------------------------------------------------------
    // Multiplier control
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (MulStart) w_state_nxt = S_RUN;
            S_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == c_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign MulBusy   = w_busy;
    assign MulDone   = w_done;
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_mulout <= '0;
        end else if ((r_state == S_IDLE) && MulStart) begin
            r_mcand  <= r_a;
            r_mplier <= r_wd;
`ifdef MC_DATAPATH_MLA_EN
            r_acc    <= r_aluout;
`else
            r_acc    <= '0;
`endif
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cw'(1);
            if (r_cnt == c_last) r_mulout <= w_acc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_datapath_mul
// Brief    : Randomised self-checking bench for mc_datapath_mul (XLEN = 32).
// Revision : 1.0
// ============================================================================
module tb_mc_datapath_mul;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] Adr, WriteData, ReadData;
    logic [31:0]     Instr;
    logic [3:0]      ALUFlags;
    logic            PCWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, MulStart;
    logic [1:0]      RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]      ALUControl;
    logic            MulBusy, MulDone;

    always #5 clk = ~clk;

    mc_datapath_mul #(.XLEN(XLEN)) u_dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData),
        .ReadData(ReadData), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
    );

    int              n_vec = 0;
    int              n_err = 0;
    logic [XLEN-1:0] rf_m [0:14];
    logic [XLEN-1:0] pc_m;
    logic [XLEN-1:0] mul_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference ALU: {N,Z,C,V, result}, from plain integer arithmetic
    function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        c, v;
        longint      sa, sb, s, lim;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lim = 64'sd2147483648;
        c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                r = a + b; s = sa + sb;
                c = ((64'(a) + 64'(b)) >> 32) != 64'd0;
                v = (s >= lim) || (s < -lim);
            end
            3'd1: begin
                r = a - b; s = sa - sb;
                c = (a >= b);
                v = (s >= lim) || (s < -lim);
            end
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            default: r = b;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    function automatic logic [31:0] ext_ref(input logic [1:0] mode, input logic [31:0] i);
        case (mode)
            2'd0:    return 32'(i[7:0]);
            2'd1:    return 32'(i[11:0]);
            2'd2:    return 32'(longint'($signed(i[23:0])) * 4);
            default: return 32'd0;
        endcase
    endfunction

    task automatic set_instr(input logic [31:0] iw);
        ReadData = iw; IRWrite = 1'b1; RegWrite = 1'b0;
        tick;
        IRWrite = 1'b0;
    endtask

    task automatic wr_reg(input int r, input logic [31:0] v);
        set_instr(32'(r) << 12);
        ReadData = v; ResultSrc = 2'b01;
        tick;
        RegWrite = 1'b1;
        tick;
        RegWrite = 1'b0;
        rf_m[r] = v;
    endtask

    task automatic rd_check(input int r);
        RegSrc = 2'b00;
        set_instr(32'(r));
        tick;
        chk($sformatf("reg_r%0d", r), WriteData, rf_m[r]);
    endtask

    task automatic chk_reset(input string tag);
        AdrSrc = 1'b0; #1;
        chk({tag, "_pc"}, Adr, 0);
        chk({tag, "_wd"}, WriteData, 0);
        chk({tag, "_ir"}, Instr, 0);
        chk({tag, "_mulst"}, {MulBusy, MulDone}, 0);
        AdrSrc = 1'b1; ResultSrc = 2'b11; #1;
        chk({tag, "_mulout"}, Adr, 0);
        ResultSrc = 2'b01; #1;
        chk({tag, "_data"}, Adr, 0);
        ResultSrc = 2'b00; #1;
        chk({tag, "_aluout"}, Adr, 0);
        ResultSrc = 2'b10; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUControl = 3'd0; #1;
        chk({tag, "_a_plus_wd"}, Adr, 0);
    endtask

    task automatic alu_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [35:0] m;
        wr_reg(1, a);
        wr_reg(2, b);
        RegSrc = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUControl = op;
        ResultSrc = 2'b10; AdrSrc = 1'b1;
        set_instr(32'h0001_0002);
        tick;
        m = alu_ref(op, a, b);
        chk($sformatf("alu_op%0d_res", op), Adr, m[31:0]);
        chk($sformatf("alu_op%0d_flags", op), ALUFlags, m[35:32]);
    endtask

    // Loads A/WriteData/ALUOut, runs one multiply and checks the handshake timing
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [7:0] imm, input string tag);
        int          poke;
        logic [31:0] exp;
        wr_reg(1, a);
        wr_reg(2, b);
        RegSrc = 2'b10; ALUSrcA = 1'b0; ALUSrcB = 2'b01; ImmSrc = 2'b00;
        ALUControl = 3'b101; ResultSrc = 2'b11; AdrSrc = 1'b1; MulStart = 1'b0;
        set_instr({12'h000, 4'h1, 4'h2, 4'h0, imm});
        tick;
        exp = a * b;
`ifdef MC_DATAPATH_MLA_EN
        exp = exp + 32'(imm);
`endif
        poke = $urandom_range(1, XLEN);
        chk({tag, "_pre"}, {MulBusy, MulDone}, 0);
        MulStart = 1'b1;
        tick;
        MulStart = 1'b0;
        for (int i = 1; i <= XLEN + 1; i++) begin
            chk({tag, "_st"}, {MulBusy, MulDone}, (i <= XLEN) ? 2'b10 : 2'b01);
            if (i == XLEN + 1) chk({tag, "_out"}, Adr, exp);
            MulStart = (i == poke);
            tick;
        end
        MulStart = 1'b0;
        chk({tag, "_post"}, {MulBusy, MulDone}, 0);
        chk({tag, "_hold"}, Adr, exp);
        mul_m = exp;
    endtask

    logic [31:0] iw, a, b;
    logic [1:0]  mode;
    int          ph, cnt;

    initial begin
        reset = 1'b1; ReadData = '0;
        PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; ALUSrcA = 0; MulStart = 0;
        RegSrc = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
        tick; tick;
        chk_reset("por");
        reset = 1'b0;
        pc_m  = '0;

        // Fetch: PC + 4 through the ALU
        for (int i = 0; i < 5; i++) begin
            iw = (i == 0) ? 32'hE281_1005 : $urandom;
            ReadData = iw; IRWrite = 1; PCWrite = 1; ALUSrcA = 1; ALUSrcB = 2'b10;
            ALUControl = 3'd0; ResultSrc = 2'b10; AdrSrc = 0;
            #1 chk("fetch_adr", Adr, pc_m);
            tick;
            pc_m = pc_m + 4;
            chk("fetch_ir", Instr, iw);
            chk("fetch_pc", Adr, pc_m);
        end
        IRWrite = 0; PCWrite = 0;

        alu_vec(3'd0, 32'h7FFF_FFFF, 32'd1);
        alu_vec(3'd1, 32'd5, 32'd5);
        alu_vec(3'd1, 32'd3, 32'd5);
        for (int i = 0; i < 14; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            alu_vec(3'($urandom_range(0, 7)), a, b);
        end

        // Immediate extension, routed to Adr via the pass-b ALU op
        for (int i = 0; i < 8; i++) begin
            iw = $urandom; mode = 2'(i % 4);
            ImmSrc = mode; ALUSrcB = 2'b01; ALUControl = 3'b101; ResultSrc = 2'b10; AdrSrc = 1;
            set_instr(iw);
            chk("ext_imm", Adr, ext_ref(mode, iw));
            chk("ext_flags", ALUFlags, {ext_ref(mode, iw) >> 31, ext_ref(mode, iw) == 0, 2'b00});
        end

        do_mul(32'd7, 32'd6, 8'd100, "mul_7x6");
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'($urandom), "mul_trunc");
        for (int i = 0; i < 4; i++) do_mul($urandom, $urandom, 8'($urandom), "mul_rand");

        // Multiply-form writeback to R3, then a discarded R15 write
        wr_reg(3, 32'h1234_5678);
        do_mul($urandom, $urandom, 8'($urandom), "mul_wb");
        ResultSrc = 2'b11;
        set_instr(32'hE003_0291);
        RegWrite = 1;
        tick;
        RegWrite = 0;
        rf_m[3] = mul_m;
        rd_check(3);
        set_instr(32'h0000_F000);
        ReadData = 32'hDEAD_BEEF; ResultSrc = 2'b01;
        tick;
        RegWrite = 1;
        tick;
        RegWrite = 0;
        for (int r = 1; r <= 3; r++) rd_check(r);

        // MulStart held high: DONE cycle ignores it, the following IDLE accepts it
        do_mul(32'd11, 32'd13, 8'd9, "mul_b2b_setup");
        MulStart = 1;
        tick;
        for (int j = 1; j <= 2 * (XLEN + 2); j++) begin
            ph = j % (XLEN + 2);
            chk("b2b_st", {MulBusy, MulDone},
                (ph >= 1 && ph <= XLEN) ? 2'b10 : ((ph == XLEN + 1) ? 2'b01 : 2'b00));
            if (ph == XLEN + 1) chk("b2b_out", Adr, mul_m);
            tick;
        end
        MulStart = 0;

        // Reset in the middle of a multiply
        tick; tick;
        MulStart = 1;
        tick;
        MulStart = 0;
        for (int i = 0; i < 10; i++) tick;
        chk("mid_busy", {MulBusy, MulDone}, 2'b10);
        reset = 1;
        tick;
        AdrSrc = 1; ResultSrc = 2'b11; #1;
        chk("rst_mulout", Adr, 0);
        chk("rst_st", {MulBusy, MulDone}, 0);
        tick;
        chk_reset("rst_mid");
        reset = 0;
        cnt = 0;
        for (int i = 0; i < XLEN + 8; i++) begin
            tick;
            if (MulBusy || MulDone) cnt++;
        end
        chk("rst_no_done", cnt, 0);
        AdrSrc = 0; #1;
        chk("rst_pc", Adr, 0);
        AdrSrc = 1; ResultSrc = 2'b11; #1;
        chk("rst_mulout_after", Adr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
